// File: rtl/systolic_input_skewer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// systolic_input_skewer
//
// Feeds an 8x8 weight-stationary systolic array. Column beats arrive over a
// valid/ready handshake and are skewed diagonally, so array row r sees its
// pixel r ticks after row 0. After the last beat of a tile, the skewer pushes
// DRAIN_CYCLES zero ticks so every partial sum reaches the bottom row. It then
// pulses tile_done.
//
// Optional feature macro: SKEWER_BYPASS_EN
//   When defined, this adds the skew_bypass input. The input is sampled on
//   the first beat of a tile and held for the whole tile. In bypass mode,
//   every lane uses a single register, so all lanes show a beat together.
//
// Ports
//   clk                clock, rising edge
//   rst_n              asynchronous active-low reset
//   in_valid           beat present
//   in_ready           beat can be accepted (combinational from state)
//   in_data            beat; lane r = in_data[r*DATA_W +: DATA_W]
//   in_last            final beat of the tile
//   skew_bypass        (SKEWER_BYPASS_EN only) per-tile bypass request
//   pixel_row_out_vec  skewed pixels to the array
//   enable_cycle       array advance strobe, aligned with the pixels
//   reset_psum         psum clear, aligned with the first beat's output
//   busy               FSM is not idle
//   tile_done          one-cycle pulse at the end of the drain
//   tile_beats         beat count of the last completed tile
// ---------------------------------------------------------------------------
module systolic_input_skewer #(
    parameter int ROWS         = 8,
    parameter int DATA_W       = 8,
    parameter int DRAIN_CYCLES = 15,
    parameter int CNT_W        = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ROWS*DATA_W-1:0]   in_data,
    input  logic                     in_last,
`ifdef SKEWER_BYPASS_EN
    input  logic                     skew_bypass,
`endif
    output logic [ROWS*DATA_W-1:0]   pixel_row_out_vec,
    output logic                     enable_cycle,
    output logic                     reset_psum,
    output logic                     busy,
    output logic                     tile_done,
    output logic [CNT_W-1:0]         tile_beats
);

    // The drain counter runs one step past DRAIN_CYCLES. That extra,
    // non-shifting step is the cycle in which tile_done is registered.
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

    state_t               r_state;
    logic [DRAIN_W-1:0]   r_drain_cnt;
    logic [CNT_W-1:0]     r_beat_cnt;
    logic                 w_accept;
    logic                 w_drain_shift;
    logic                 w_tick;
    logic                 w_bypass;

    // Ready depends only on state, so upstream never sees a comb loop through valid.
    assign in_ready      = (r_state != DRAIN);
    assign w_accept      = in_valid & in_ready;
    assign w_drain_shift = (r_state == DRAIN) && (r_drain_cnt != DRAIN_W'(DRAIN_CYCLES));
    assign w_tick        = w_accept | w_drain_shift;

`ifdef SKEWER_BYPASS_EN
    logic r_bypass;

    // On the first beat, the live input applies. Later beats and the drain
    // use the value that was latched when the tile started.
    assign w_bypass = (r_state == IDLE) ? skew_bypass : r_bypass;

    // Latch the bypass request once per tile, on its first accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bypass <= 1'b0;
        end else if (w_accept && (r_state == IDLE)) begin
            r_bypass <= skew_bypass;
        end
    end
`else
    assign w_bypass = 1'b0;
`endif

    // Tile-level control. The FSM moves IDLE -> FEED -> DRAIN -> IDLE.
    // enable_cycle mirrors the tick of the previous edge, so it lines up
    // with the pixel registers. reset_psum marks the first beat.
    // tile_done, busy and tile_beats update on the extra, non-shifting
    // drain step that follows the last zero tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_drain_cnt  <= '0;
            r_beat_cnt   <= '0;
            enable_cycle <= 1'b0;
            reset_psum   <= 1'b0;
            busy         <= 1'b0;
            tile_done    <= 1'b0;
            tile_beats   <= '0;
        end else begin
            enable_cycle <= w_tick;
            reset_psum   <= 1'b0;
            tile_done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_beat_cnt  <= CNT_W'(1);
                        r_drain_cnt <= '0;
                        reset_psum  <= 1'b1;
                        busy        <= 1'b1;
                        r_state     <= in_last ? DRAIN : FEED;
                    end
                end
                FEED: begin
                    if (w_accept) begin
                        if (r_beat_cnt != '1) begin
                            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        end
                        if (in_last) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt == DRAIN_W'(DRAIN_CYCLES)) begin
                        r_state    <= IDLE;
                        busy       <= 1'b0;
                        tile_done  <= 1'b1;
                        tile_beats <= r_beat_cnt;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Each lane owns a chain of lane+1 registers, and its last stage drives
    // the output. Every chain advances on a tick and holds otherwise. During
    // the drain, zeros enter the chains. In bypass mode, the last stage loads
    // the lane directly and the earlier stages fill with zeros.
    genvar gr;
    generate
        for (gr = 0; gr < ROWS; gr++) begin : g_lane
            logic [DATA_W-1:0] r_stage [0:gr];
            logic [DATA_W-1:0] w_lane_in;

            assign w_lane_in = (r_state == DRAIN) ? '0 : in_data[gr*DATA_W +: DATA_W];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s <= gr; s++) begin
                        r_stage[s] <= '0;
                    end
                end else if (w_tick) begin
                    if (w_bypass) begin
                        for (int s = 0; s < gr; s++) begin
                            r_stage[s] <= '0;
                        end
                        r_stage[gr] <= w_lane_in;
                    end else begin
                        r_stage[0] <= w_lane_in;
                        for (int s = 1; s <= gr; s++) begin
                            r_stage[s] <= r_stage[s-1];
                        end
                    end
                end
            end

            assign pixel_row_out_vec[gr*DATA_W +: DATA_W] = r_stage[gr];
        end
    endgenerate

endmodule

// File: doc/systolic_input_skewer.md
# systolic_input_skewer

Upstream feeder for the 8x8 weight-stationary systolic array. It accepts one 8-pixel column beat per cycle over a valid/ready handshake. It skews the beat diagonally so array row r sees its pixel r cycles after row 0. It generates the array's `enable_cycle` and `reset_psum` controls, then drains the array with zero pixels after the last beat so every partial sum reaches the bottom row before signalling tile completion.

## Interface
- `ROWS`, 8: array rows (pixel lanes).
- `DATA_W`, 8: pixel width.
- `DRAIN_CYCLES`, 15: zero-fill cycles after the last beat (2*ROWS-1).
- `CNT_W`, 16: beat counter width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  beat present.
- `in_ready`  out  1  skewer can accept a beat.
- `in_data`  in  ROWS*DATA_W  beat; lane r = `in_data[r*DATA_W +: DATA_W]`.
- `in_last`  in  1  beat is the final beat of the tile.
- `pixel_row_out_vec`  out  ROWS*DATA_W  skewed pixels to array `pixel_row_in_vec`.
- `enable_cycle`  out  1  array advance strobe.
- `reset_psum`  out  1  array psum clear; high with the first beat of a tile.
- `busy`  out  1  state is not IDLE.
- `tile_done`  out  1  one-cycle pulse at the end of drain.
- `tile_beats`  out  CNT_W  beats accepted in the last completed tile; valid from `tile_done`, held until the next `tile_done`.

## Operation
- FSM states: IDLE, FEED, DRAIN.
- IDLE: `in_ready`=1. An accepted beat (`in_valid`&`in_ready`) moves the FSM to FEED, or straight to DRAIN if `in_last`=1.
- FEED: `in_ready`=1. An accepted beat with `in_last`=1 moves the FSM to DRAIN. No beat means a stall: no shift, and `enable_cycle`=0 for that cycle.
- DRAIN: `in_ready`=0. Zeros shift in every cycle for DRAIN_CYCLES cycles, then `tile_done`=1 and the FSM returns to IDLE.
- Skew: lane r has a shift chain of r+1 registers. Output lane r is the last stage of its chain.
- All chains shift together on a "tick". A tick is an accepted beat or a DRAIN cycle. Chains hold otherwise.
- Beat counter: cleared on the first beat of a tile and incremented per accepted beat. It saturates at 2^CNT_W-1 and does not wrap. It is copied to `tile_beats` on `tile_done`.
- `reset_psum` is high only in the output cycle of the first beat of each tile.
- Reset, including mid-FEED or mid-DRAIN: all chains, outputs, counters and FSM clear immediately. The tile is abandoned and no `tile_done` is issued.

## Timing
- Reset values:
  - `pixel_row_out_vec`=0, `enable_cycle`=0, `reset_psum`=0, `busy`=0, `tile_done`=0, `tile_beats`=0.
  - `in_ready`=1 once `rst_n` deasserts.
- All outputs except `in_ready` are registered.
- `in_ready` is combinational from state only. It does not depend on `in_valid`.
- A tick at edge k drives `enable_cycle`=1 during cycle k+1.
- Lane 0 shows beat data in cycle k+1. Lane r shows it in cycle k+1+r, provided ticks are continuous.
- `enable_cycle` and pixel outputs are aligned, so the array samples both at the same edge.
- Tile with N beats and no stalls:
  - `enable_cycle` is high for N+DRAIN_CYCLES consecutive cycles.
  - `tile_done` pulses in the cycle after the last drain enable.
  - `busy` falls in the same cycle as `tile_done`.
- A beat offered during the `tile_done` cycle is accepted (state IDLE). Back-to-back tiles therefore have zero idle gap.

## Configuration
- Macro: `SKEWER_BYPASS_EN`.
- Defined: adds input port `skew_bypass` (1 bit), sampled on the first beat of a tile and held for that tile. When it is 1, every lane uses a 1-register path: all lanes show the beat in cycle k+1 and zeros fill the skew. Drain length is unchanged.
- Not defined: the port is absent and skew is always applied.

## Test plan
- Reset: hold `rst_n`=0 with `in_valid`=1 → all outputs 0, `in_ready`=1 after release, no enable pulses.
- 3-beat tile, lane 0 = 1, 4, 7 and other lanes 0, `in_last` on beat 3 →
  - lane 0 shows 1, 4, 7 in cycles 1-3; `reset_psum` high in cycle 1 only;
  - `enable_cycle` high 18 cycles; `tile_done` in cycle 19; `tile_beats`=3.
- Skew: a single beat with lane r = r+1, `in_last`=1 → lane r shows r+1 exactly in cycle 1+r and 0 otherwise.
- Stall: 4-beat tile with `in_valid` low for 2 cycles after beat 2 → `enable_cycle` low for exactly those 2 cycles, outputs hold, final lane alignment unchanged, `tile_beats`=4.
- Reset mid-DRAIN: assert `rst_n`=0 at drain cycle 5 → outputs 0 asynchronously, no `tile_done`, next tile runs normally with `reset_psum`.
- With `SKEWER_BYPASS_EN` and `skew_bypass`=1: a single beat with lane r = r+1 → all lanes show their value in cycle 1.
